ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite slave that backs a word-organised on-chip SRAM and sits directly downstream of the core's AHB master, behind the interconnect. It decodes address-phase signals, inserts a programmable number of wait states, performs byte/halfword/word reads and writes with lane strobes, and returns a two-cycle ERROR response for illegal accesses. It is the default instruction/data memory target for the core's IFU and LSU traffic.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, data bus width; only 32 supported
- MEM_DEPTH, 1024, number of 32-bit words
- BASE_ADDR, 32'h0000_0000, first byte address mapped; must be 4·MEM_DEPTH aligned
- WAIT_STATES, 0, wait cycles inserted per accepted NONSEQ/SEQ transfer (0..7)
- HCLK  in  1  clock; all logic on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- HSEL  in  1  slave select from decoder
- HADDR  in  ADDR_WIDTH  byte address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1=write
- HSIZE  in  3  000 byte, 001 halfword, 010 word; others illegal
- HBURST  in  3  accepted, not used for decode
- HPROT  in  4  accepted, ignored
- HMASTLOCK  in  1  accepted, ignored
- HWDATA  in  DATA_WIDTH  write data, valid in data phase
- HREADY  in  1  bus ready (previous transfer completing)
- HREADYOUT  out  1  this slave's ready
- HRDATA  out  DATA_WIDTH  read data
- HRESP  out  1  0=OKAY, 1=ERROR

## Operation
- Accept: address phase latched when HSEL && HREADY && HTRANS[1]; captures word index, HADDR[1:0], HSIZE, HWRITE. HTRANS IDLE/BUSY or HSEL=0 with HREADY -> nothing latched; slave returns to IDLE (zero-wait OKAY).
- Legality checked at accept: address in [BASE_ADDR, BASE_ADDR+4·MEM_DEPTH); HSIZE ≤ 010; halfword needs HADDR[0]=0; word needs HADDR[1:0]=00. Any failure -> ERR1.
- States: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0. Accept legal -> WAIT if WAIT_STATES>0 else DATA.
  - WAIT: HREADYOUT=0; 3-bit counter loaded with WAIT_STATES-1 at accept, decrements; at 0 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0. Write committed at end of this cycle. Same cycle may accept next transfer (-> WAIT/DATA/ERR1), else -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2. ERR2: HREADYOUT=1, HRESP=1; may accept next transfer as in DATA.
- Byte strobes: byte -> 4'b0001<<HADDR[1:0]; halfword -> 4'b0011<<HADDR[1:0]; word -> 4'b1111. Write updates only strobed lanes from the same HWDATA lanes (lane-aligned, no shifting).
- Read: HRDATA = full 32-bit word mem[index] during DATA of a read; master extracts lanes. HRDATA=0 in all other cycles.
- Illegal accesses never write memory; ERROR reads return HRDATA=0.
- Memory array is not reset; contents undefined after power-up.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, counter 0.
- Reset asserted mid-transfer: immediate abort to IDLE; pending write not committed.
- Latency: address phase cycle N; data phase completes cycle N+1+WAIT_STATES (HREADYOUT=1 that cycle).
- Back-to-back zero-wait: one transfer per cycle; write at N then read same word at N+1 returns new data (write commits at edge ending N+1 data phase, read data phase is N+2).
- Write-then-read same address with wait states: read data phase strictly after write commit; no forwarding needed.
- HREADY low from another slave while HSEL high: no accept; state unchanged.
- ERROR response always exactly 2 cycles regardless of WAIT_STATES.

## Test plan
- WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 back-to-back -> write OKAY in 1 cycle, read HRDATA=0xDEADBEEF next cycle, HRESP=0.
- Byte write 0xAA at 0x13 (HWDATA=0xAA000000) over word 0x11223344 -> read 0x10 returns 0xAA223344.
- WAIT_STATES=3: read @0x20 -> HREADYOUT low 3 cycles, high on 4th with data; 4 cycles total per transfer.
- Halfword write @0x21 -> HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; memory @0x20 unchanged; same for address BASE_ADDR+4·MEM_DEPTH.
- HTRANS=BUSY and IDLE with HSEL=1 -> HREADYOUT=1, HRESP=0, no memory change.
- Assert HRESETn low during WAIT of a write -> outputs return to reset values immediately; subsequent read shows old data.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave over a word-organised SRAM with programmable wait states
// and a two-cycle ERROR response for out-of-range, oversize or misaligned accesses.
module ahb_sram_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HMASTLOCK,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HRESP
);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam int LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(4 * MEM_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [LANES-1:0]      strb_q, strb_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [ADDR_WIDTH:0]   diff;
    logic                  ready, accept, legal;
    logic                  unused;

    // An address below BASE_ADDR borrows into the top bit, so one compare covers both bounds.
    assign diff   = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign ready  = (state_q != S_WAIT) && (state_q != S_ERR1);
    assign accept = ready && HSEL && HREADY && HTRANS[1];
    assign legal  = (diff < SPAN) && (HSIZE <= 3'd2) &&
                    !(HSIZE == 3'd1 && HADDR[0]) &&
                    !(HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
    assign unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        strb_d  = strb_q;
        write_d = write_q;
        if (state_q == S_WAIT) begin
            state_d = (cnt_q == 3'd0) ? S_DATA : S_WAIT;
            cnt_d   = cnt_q - 3'd1;
        end else if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else if (accept) begin
            state_d = !legal ? S_ERR1 : (WAIT_STATES > 0) ? S_WAIT : S_DATA;
            cnt_d   = 3'(WAIT_STATES - 1);
            idx_d   = diff[IW+1:2];
            write_d = HWRITE;
            strb_d  = (HSIZE == 3'd2) ? 4'b1111 :
                      (HSIZE == 3'd1) ? 4'b0011 << HADDR[1:0] : 4'b0001 << HADDR[1:0];
        end else if (HREADY) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            strb_q  <= strb_d;
            write_q <= write_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (state_q == S_DATA && write_q)
            for (int i = 0; i < LANES; i++)
                if (strb_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
    end

    assign HREADYOUT = ready;
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign HRDATA    = (state_q == S_DATA && !write_q) ? mem[idx_q] : '0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed bench driving a zero-wait and a three-wait instance of the
// SRAM slave with hand-computed expectations.
module tb_ahb_sram_slave;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        hsel [2], hwrite [2], hmastlock [2], hrdy_low [2];
    logic [31:0] haddr [2], hwdata [2];
    logic [1:0]  htrans [2];
    logic [2:0]  hsize [2], hburst [2];
    logic [3:0]  hprot [2];
    logic        hready [2], hreadyout [2], hresp [2];
    logic [31:0] hrdata [2];
    int n_cmp = 0;
    int n_err = 0;

    assign hready[0] = hrdy_low[0] ? 1'b0 : hreadyout[0];
    assign hready[1] = hrdy_low[1] ? 1'b0 : hreadyout[1];

    ahb_sram_slave #(.WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HPROT(hprot[0]),
        .HMASTLOCK(hmastlock[0]), .HWDATA(hwdata[0]), .HREADY(hready[0]),
        .HREADYOUT(hreadyout[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0])
    );

    ahb_sram_slave #(.WAIT_STATES(3)) u_ws3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HPROT(hprot[1]),
        .HMASTLOCK(hmastlock[1]), .HWDATA(hwdata[1]), .HREADY(hready[1]),
        .HREADYOUT(hreadyout[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        hwrite[d] = 1'b0;
    endtask

    task automatic addr_phase(input int d, input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel[d]   = 1'b1;
        htrans[d] = 2'b10;
        hwrite[d] = wr;
        haddr[d]  = a;
        hsize[d]  = sz;
    endtask

    // Caller sits just after a rising edge; returns just after the edge ending the data phase.
    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic rsp,
                        output logic rdy0, output logic rsp0, output int wcyc);
        addr_phase(d, wr, a, sz);
        @(posedge clk); #1;
        idle(d);
        hwdata[d] = wd;
        @(negedge clk);
        rdy0 = hreadyout[d];
        rsp0 = hresp[d];
        wcyc = 0;
        while (!hreadyout[d] && wcyc < 20) begin
            wcyc++;
            @(negedge clk);
        end
        rd  = hrdata[d];
        rsp = hresp[d];
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic rsp, rdy0, rsp0;
        int wc;
        for (int d = 0; d < 2; d++) begin
            idle(d);
            haddr[d] = '0; hwdata[d] = '0; hsize[d] = 3'd2; hburst[d] = '0;
            hprot[d] = '0; hmastlock[d] = 1'b0; hrdy_low[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_hreadyout", hreadyout[d], 1);
            check("reset_hresp", hresp[d], 0);
            check("reset_hrdata", hrdata[d], 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // zero-wait back-to-back write then read of the same word
        addr_phase(0, 1'b1, 32'h10, 3'd2);
        @(posedge clk); #1;
        hwdata[0] = 32'hDEADBEEF;
        addr_phase(0, 1'b0, 32'h10, 3'd2);
        @(negedge clk);
        check("b2b_wr_ready", hreadyout[0], 1);
        check("b2b_wr_resp", hresp[0], 0);
        @(posedge clk); #1;
        idle(0);
        @(negedge clk);
        check("b2b_rd_data", hrdata[0], 32'hDEADBEEF);
        check("b2b_rd_ready", hreadyout[0], 1);
        check("b2b_rd_resp", hresp[0], 0);
        @(posedge clk); #1;

        // lane strobes
        xfer(0, 1'b1, 32'h10, 3'd2, 32'h11223344, rd, rsp, rdy0, rsp0, wc);
        xfer(0, 1'b1, 32'h13, 3'd0, 32'hAA000000, rd, rsp, rdy0, rsp0, wc);
        check("byte_wr_resp", rsp, 0);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, rsp, rdy0, rsp0, wc);
        check("byte_rd_data", rd, 32'hAA223344);
        xfer(0, 1'b1, 32'h14, 3'd2, 32'h55667788, rd, rsp, rdy0, rsp0, wc);
        xfer(0, 1'b1, 32'h16, 3'd1, 32'hBEEF0000, rd, rsp, rdy0, rsp0, wc);
        xfer(0, 1'b0, 32'h14, 3'd2, 32'h0, rd, rsp, rdy0, rsp0, wc);
        check("half_rd_data", rd, 32'hBEEF7788);
        check("ws0_wait_cycles", wc, 0);

        // three wait states
        xfer(1, 1'b1, 32'h20, 3'd2, 32'hCAFEF00D, rd, rsp, rdy0, rsp0, wc);
        check("ws3_wr_wait", wc, 3);
        check("ws3_wr_resp", rsp, 0);
        xfer(1, 1'b0, 32'h20, 3'd2, 32'h0, rd, rsp, rdy0, rsp0, wc);
        check("ws3_rd_wait", wc, 3);
        check("ws3_rd_data", rd, 32'hCAFEF00D);
        xfer(1, 1'b1, 32'h0, 3'd2, 32'h0BADF00D, rd, rsp, rdy0, rsp0, wc);

        // error responses are two cycles, never write, and read as zero
        xfer(1, 1'b1, 32'h21, 3'd1, 32'hFFFFFFFF, rd, rsp, rdy0, rsp0, wc);
        check("err_half_rdy0", rdy0, 0);
        check("err_half_resp0", rsp0, 1);
        check("err_half_len", wc, 1);
        check("err_half_resp1", rsp, 1);
        xfer(1, 1'b1, 32'h1000, 3'd2, 32'hFFFFFFFF, rd, rsp, rdy0, rsp0, wc);
        check("err_oor_wr_resp0", rsp0, 1);
        check("err_oor_wr_len", wc, 1);
        xfer(1, 1'b0, 32'h1000, 3'd2, 32'h0, rd, rsp, rdy0, rsp0, wc);
        check("err_oor_rd_resp", rsp, 1);
        check("err_oor_rd_data", rd, 0);
        xfer(1, 1'b0, 32'h20, 3'd2, 32'h0, rd, rsp, rdy0, rsp0, wc);
        check("err_keep_20", rd, 32'hCAFEF00D);
        xfer(1, 1'b0, 32'h0, 3'd2, 32'h0, rd, rsp, rdy0, rsp0, wc);
        check("err_keep_00", rd, 32'h0BADF00D);
        xfer(0, 1'b1, 32'h12, 3'd2, 32'hFFFFFFFF, rd, rsp, rdy0, rsp0, wc);
        check("err_misaligned_word", rsp, 1);
        xfer(0, 1'b0, 32'h10, 3'd3, 32'h0, rd, rsp, rdy0, rsp0, wc);
        check("err_bad_size", rsp, 1);
        check("err_bad_size_len", wc, 1);

        // BUSY and IDLE with HSEL high are ignored
        addr_phase(0, 1'b1, 32'h10, 3'd2);
        htrans[0] = 2'b01;
        @(negedge clk);
        check("busy_ready", hreadyout[0], 1);
        @(posedge clk); #1;
        htrans[0] = 2'b00;
        hwdata[0] = 32'hFFFFFFFF;
        @(negedge clk);
        check("idle_ready", hreadyout[0], 1);
        check("idle_resp", hresp[0], 0);
        @(posedge clk); #1;
        hwdata[0] = 32'hFFFFFFFF;
        idle(0);
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, rsp, rdy0, rsp0, wc);
        check("busy_idle_nowrite", rd, 32'hAA223344);

        // HREADY low from another slave blocks the accept
        hrdy_low[0] = 1'b1;
        addr_phase(0, 1'b1, 32'h10, 3'd2);
        @(posedge clk); #1;
        hrdy_low[0] = 1'b0;
        idle(0);
        hwdata[0] = 32'hFFFFFFFF;
        @(negedge clk);
        check("hready_low_ready", hreadyout[0], 1);
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, rsp, rdy0, rsp0, wc);
        check("hready_low_nowrite", rd, 32'hAA223344);

        // reset during the wait of a write aborts it
        addr_phase(1, 1'b1, 32'h20, 3'd2);
        @(posedge clk); #1;
        idle(1);
        hwdata[1] = 32'h12345678;
        @(negedge clk);
        check("rst_mid_wait", hreadyout[1], 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ready", hreadyout[1], 1);
        check("rst_mid_resp", hresp[1], 0);
        check("rst_mid_rdata", hrdata[1], 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'h20, 3'd2, 32'h0, rd, rsp, rdy0, rsp0, wc);
        check("rst_mid_olddata", rd, 32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
